// File: rtl/snoop_resp_pkg.sv
// snoop_resp_pkg: shared state type and default parameters for the snoop response combiner
package snoop_resp_pkg;
  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_t;
  localparam int DEF_NUM_PORTS      = 4;
  localparam int DEF_DATA_W         = 8;
  localparam int DEF_TIMEOUT_CYCLES = 256;
endpackage

// File: rtl/snoop_resp_timeout_ctr.sv
// snoop_resp_timeout_ctr: collection watchdog, armed by the first response, cleared when the combined response is issued
module snoop_resp_timeout_ctr
  import snoop_resp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic i_start,
  input  logic i_clear,
  output logic o_expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic          r_run;
  logic [CW-1:0] r_cnt;
  assign o_expire = r_run && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  // clear beats start so a transaction finishing on its first handshake never arms the counter
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
    end else if (r_run && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/snoop_resp_or_combiner.sv
// snoop_resp_or_combiner: OR-combines one response per enabled snoop port into a single handshaked word
// Optional collection timeout enabled by defining SNOOP_RESP_OR_COMBINER_TIMEOUT_EN.
module snoop_resp_or_combiner
  import snoop_resp_pkg::*;
#(
  parameter int NUM_PORTS      = DEF_NUM_PORTS,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NUM_PORTS-1:0]        port_en,
  input  logic [NUM_PORTS-1:0]        in_valid,
  output logic [NUM_PORTS-1:0]        in_ready,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_timeout,
  output logic [NUM_PORTS-1:0]        out_missing
);
  if (NUM_PORTS < 2 || DATA_W < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("snoop_resp_or_combiner: invalid parameter set");
  end
  state_t               r_state, w_state_nxt;
  logic [DATA_W-1:0]    r_acc, w_or;
  logic [NUM_PORTS-1:0] r_got, w_fire, w_got_nxt;
  logic                 w_collect, w_done, w_expire, w_to_send, w_send_fire;
  assign w_collect   = r_state == COLLECT;
  assign in_ready    = w_collect ? port_en & ~r_got : '0;
  assign w_fire      = in_valid & in_ready;
  assign w_got_nxt   = r_got | w_fire;
  assign w_done      = w_collect && (&(w_got_nxt | ~port_en)) && (|port_en);
  assign w_to_send   = w_done || w_expire;
  assign out_valid   = r_state == SEND;
  assign w_send_fire = out_valid && out_ready;
  assign out_data    = r_acc;
  // merge every word accepted this cycle, regardless of how many ports fire together
  always_comb begin
    w_or = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      w_or = w_or | (w_fire[i] ? in_data[i*DATA_W +: DATA_W] : '0);
  end
  // leave COLLECT once all required ports are in (or the watchdog fires), leave SEND on consumption
  always_comb begin
    w_state_nxt = r_state;
    if (w_collect) w_state_nxt = w_to_send ? SEND : COLLECT;
    else           w_state_nxt = out_ready ? COLLECT : SEND;
  end
  // state, accumulator and contribution mask; acc/got hold still in SEND because no port can fire there
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= COLLECT;
      r_acc   <= '0;
      r_got   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_send_fire) begin
        r_acc <= '0;
        r_got <= '0;
      end else begin
        r_acc <= r_acc | w_or;
        r_got <= w_got_nxt;
      end
    end
  end
`ifdef SNOOP_RESP_OR_COMBINER_TIMEOUT_EN
  logic                 w_start, w_expire_raw, r_timeout;
  logic [NUM_PORTS-1:0] r_missing;
  assign w_start  = w_collect && (|w_fire) && (r_got == '0);
  assign w_expire = w_collect && w_expire_raw;
  snoop_resp_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_start (w_start),
    .i_clear (w_to_send),
    .o_expire(w_expire_raw)
  );
  // a forced response records which enabled ports never answered; a real completion in the same cycle wins
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_timeout <= 1'b0;
      r_missing <= '0;
    end else if (w_send_fire) begin
      r_timeout <= 1'b0;
      r_missing <= '0;
    end else if (w_expire && !w_done) begin
      r_timeout <= 1'b1;
      r_missing <= port_en & ~w_got_nxt;
    end
  end
  assign out_timeout = r_timeout;
  assign out_missing = r_missing;
`else
  assign w_expire    = 1'b0;
  assign out_timeout = 1'b0;
  assign out_missing = '0;
`endif
endmodule

// File: tb/tb_snoop_resp_or_combiner.sv
// tb_snoop_resp_or_combiner: directed and random transactions checked against a transaction-level model
module tb_snoop_resp_or_combiner;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  port_en = 4'hF;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_timeout;
  logic [3:0]  out_missing;
  int          errors = 0;
  int          checks = 0;

  snoop_resp_or_combiner #(
    .NUM_PORTS(4),
    .DATA_W(8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .port_en(port_en),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_timeout(out_timeout),
    .out_missing(out_missing)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // One transaction: enabled port i offers word w[i] from collect cycle d[i] and holds it until accepted.
  // Disabled ports assert valid throughout with junk. Expected result is the OR of the enabled words,
  // visible the cycle after the last acceptance, held for bp stalled cycles before consumption.
  task automatic txn(input logic [3:0] en, input logic [31:0] w, input int d0, input int d1,
                     input int d2, input int d3, input int bp, input logic hold_ff);
    logic [3:0] pend;
    logic [7:0] exp_d;
    int         dl[4];
    int         c;
    dl    = '{d0, d1, d2, d3};
    pend  = en;
    exp_d = '0;
    c     = 0;
    for (int i = 0; i < 4; i++) if (en[i]) exp_d = exp_d | w[i*8 +: 8];
    port_en   = en;
    out_ready = 1'b0;
    while (pend != 0 && c < 40) begin
      for (int i = 0; i < 4; i++) begin
        in_valid[i]      = pend[i] ? (c >= dl[i]) : !en[i];
        in_data[i*8 +: 8] = pend[i] ? w[i*8 +: 8] : 8'($urandom);
      end
      @(negedge aclk);
      chk("collect_in_ready", in_ready, pend);
      chk("collect_out_valid", out_valid, 0);
      pend = pend & ~in_valid;
      step();
      c++;
    end
    chk("collect_complete", pend, 0);
    for (int k = 0; k <= bp; k++) begin
      out_ready = (k == bp);
      in_valid  = hold_ff ? 4'b0001 : 4'($urandom);
      in_data   = hold_ff ? 32'h000000FF : $urandom;
      @(negedge aclk);
      chk("send_out_valid", out_valid, 1);
      chk("send_out_data", out_data, exp_d);
      chk("send_in_ready", in_ready, 0);
      chk("send_timeout", out_timeout, 0);
      chk("send_missing", out_missing, 0);
      step();
    end
  endtask

  initial begin
    int lat;
    // reset state
    step();
    @(negedge aclk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_timeout", out_timeout, 0);
    chk("rst_missing", out_missing, 0);
    chk("rst_in_ready", in_ready, 4'hF);
    aresetn = 1'b1;
    step();

    // skewed arrival, then backpressure with port 0 re-offering 8'hFF; 8'hFF opens the next transaction
    txn(4'hF, 32'h80040201, 1, 3, 4, 7, 5, 1'b1);
    txn(4'hF, 32'h000000FF, 0, 0, 0, 0, 0, 1'b0);
    // all four ports in one cycle
    txn(4'hF, 32'h01402010, 0, 0, 0, 0, 0, 1'b0);
    // partial enable, disabled ports valid throughout
    txn(4'b0101, 32'h55300A03, 0, 0, 2, 0, 1, 1'b0);

    // nothing enabled: no readiness, no output
    port_en  = 4'h0;
    in_valid = 4'hF;
    in_data  = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk("noen_in_ready", in_ready, 0);
      chk("noen_out_valid", out_valid, 0);
      step();
    end

    // reset in the middle of a collection discards partial data
    port_en  = 4'hF;
    in_valid = 4'b0011;
    in_data  = 32'h0000F00F;
    @(negedge aclk);
    chk("prerst_in_ready", in_ready, 4'hF);
    step();
    in_valid = '0;
    @(negedge aclk);
    chk("prerst_held_off", in_ready, 4'b1100);
    aresetn = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 4'hF);
    step();
    aresetn = 1'b1;
    step();
    txn(4'hF, 32'h20100402, 0, 1, 0, 2, 0, 1'b0);

    // random transactions
    for (int t = 0; t < 20; t++)
      txn(4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 5), $urandom_range(0, 5),
          $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3), 1'b0);

`ifdef SNOOP_RESP_OR_COMBINER_TIMEOUT_EN
    // only ports 0 and 1 answer; the watchdog forces the response out
    port_en   = 4'hF;
    out_ready = 1'b0;
    in_valid  = 4'b0011;
    in_data   = 32'h00000201;
    @(negedge aclk);
    chk("to_accept", in_ready, 4'hF);
    step();
    in_valid = '0;
    lat = 0;
    @(negedge aclk);
    while (!out_valid && lat < 30) begin
      step();
      @(negedge aclk);
      lat++;
    end
    chk("to_latency_window", (lat >= 7 && lat <= 10), 1);
    chk("to_out_valid", out_valid, 1);
    chk("to_out_data", out_data, 8'h03);
    chk("to_flag", out_timeout, 1);
    chk("to_missing", out_missing, 4'b1100);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge aclk);
    chk("to_clear_valid", out_valid, 0);
    chk("to_clear_flag", out_timeout, 0);
    chk("to_clear_missing", out_missing, 0);
    step();
`else
    lat = 0;
`endif

    in_valid  = '0;
    out_ready = 1'b0;
    @(negedge aclk);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, port_en);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
